// File: rtl/vector_load_buffer.sv
// Operand buffer for the MAC array. It fills from a multi-lane stream or from
// single-word writes, and presents a registered parallel snapshot of every entry.
module vector_load_buffer #(
   parameter int WIDTH   = 16,
   parameter int SIZE    = 64,
   parameter int LOGSIZE = 6,
   parameter int LANES   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [LANES*WIDTH-1:0]   s_data,
   input  logic                     wr_en,
   input  logic [LOGSIZE-1:0]       wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     load_done,
   output logic signed [WIDTH-1:0]  data_out [SIZE],
   output logic                     out_valid
);

   typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

   state_t                   state_reg, state_next;
   logic [LOGSIZE-1:0]       ptr_reg;
   logic signed [WIDTH-1:0]  mem [SIZE];
   logic                     beat;
   logic                     last_beat;
   logic [SIZE-1:0]          stream_hit;
   logic [SIZE-1:0]          rand_hit;
   logic [SIZE*WIDTH-1:0]    lane_data;

   assign beat      = s_valid && s_ready;
   assign last_beat = (ptr_reg == LOGSIZE'(SIZE - LANES));

   // ptr is always lane-aligned, so entry gi can only be written by lane gi%LANES
   // of the beat whose base is gi rounded down to a lane boundary.
   generate
      for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
         assign stream_hit[gi] = beat && (ptr_reg == LOGSIZE'(gi - (gi % LANES)));
         assign rand_hit[gi]   = wr_en && (wr_addr == LOGSIZE'(gi));
         assign lane_data[gi*WIDTH +: WIDTH] = s_data[(gi % LANES)*WIDTH +: WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < SIZE; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < SIZE; i++) begin
            if (stream_hit[i])
               mem[i] <= lane_data[i*WIDTH +: WIDTH];
            else if (rand_hit[i])
               mem[i] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear)
         ptr_reg <= '0;
      else if (beat)
         ptr_reg <= last_beat ? '0 : ptr_reg + LOGSIZE'(LANES);
   end

   // Snapshot of pre-edge contents; a clear still shows the old contents for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SIZE; i++) data_out[i] <= '0;
         out_valid <= 1'b0;
      end else begin
         data_out  <= mem;
         out_valid <= load_done;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= LOAD;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = LOAD;
      end else begin
         case (state_reg)
            LOAD:    if (beat && last_beat) state_next = FULL;
            FULL:    state_next = FULL;
            default: state_next = LOAD;
         endcase
      end
   end

   always_comb begin
      s_ready   = 1'b0;
      load_done = 1'b0;
      case (state_reg)
         LOAD:    s_ready   = !clear && !reset;
         FULL:    load_done = 1'b1;
         default: ;
      endcase
   end

endmodule
